// File: rtl/vending_customer_pkg.sv
// Shared codes and constants for the vending machine customer agent.
// Service/item/coin encodings match the machine's coin/item interface.
package vending_customer_pkg;

    typedef enum logic [1:0] {
        SVC_OFF  = 2'b00,
        SVC_ON   = 2'b01,
        SVC_BUSY = 2'b10
    } svc_t;

    typedef enum logic [1:0] {
        ITEM_NONE = 2'b00,
        ITEM_A    = 2'b01,
        ITEM_B    = 2'b10,
        ITEM_C    = 2'b11
    } item_t;

    typedef enum logic [1:0] {
        COIN_50 = 2'd0,
        COIN_10 = 2'd1,
        COIN_5  = 2'd2,
        COIN_1  = 2'd3
    } coin_t;

    localparam int COIN_VAL_50 = 50;
    localparam int COIN_VAL_10 = 10;
    localparam int COIN_VAL_5  = 5;
    localparam int COIN_VAL_1  = 1;

    localparam int DEF_COST_A = 8;
    localparam int DEF_COST_B = 15;
    localparam int DEF_COST_C = 22;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ON   = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_OFF  = 3'd3,
        ST_CHECK     = 3'd4
    } state_t;

    // Cost of a requested item; NONE costs nothing.
    function automatic logic [9:0] item_cost(input logic [1:0] item,
                                             input int cost_a,
                                             input int cost_b,
                                             input int cost_c);
        case (item)
            ITEM_A:  return 10'(cost_a);
            ITEM_B:  return 10'(cost_b);
            ITEM_C:  return 10'(cost_c);
            default: return 10'd0;
        endcase
    endfunction

endpackage

// File: rtl/vending_customer_coin_valuer.sv
// Combinational NTD value of a set of coin counts (50/10/5/1).
// Wide enough that 3-bit counts never overflow (max 7*66 = 462).
module coin_valuer
    import vending_customer_pkg::*;
#(
    parameter int CW = 2
) (
    input  logic [CW-1:0] n50,
    input  logic [CW-1:0] n10,
    input  logic [CW-1:0] n5,
    input  logic [CW-1:0] n1,
    output logic [9:0]    value
);

    assign value = 10'(COIN_VAL_50 * n50 + COIN_VAL_10 * n10 +
                       COIN_VAL_5 * n5 + COIN_VAL_1 * n1);

endmodule

// File: rtl/vending_customer.sv
// Customer-side agent for the vending machine: issues one purchase per
// start pulse, follows ON->BUSY->OFF, and checks delivered item/change.
module vending_customer
    import vending_customer_pkg::*;
#(
    parameter int COST_A  = DEF_COST_A,
    parameter int COST_B  = DEF_COST_B,
    parameter int COST_C  = DEF_COST_C,
    parameter int TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] req_item,
    input  logic [1:0] req_n50,
    input  logic [1:0] req_n10,
    input  logic [1:0] req_n5,
    input  logic [1:0] req_n1,
    input  logic [1:0] svc_in,
    input  logic [1:0] item_in,
    input  logic [2:0] chg_n50,
    input  logic [2:0] chg_n10,
    input  logic [2:0] chg_n5,
    input  logic [2:0] chg_n1,
    output logic [1:0] coin_n50,
    output logic [1:0] coin_n10,
    output logic [1:0] coin_n5,
    output logic [1:0] coin_n1,
    output logic [1:0] item_req,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       timeout,
    output logic [7:0] paid_value,
    output logic [9:0] change_value,
    output logic [1:0] got_item,
    output logic [7:0] txn_count
);

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_next;
    logic [7:0] wd;
    logic [1:0] item_q, n50_q, n10_q, n5_q, n1_q;
    logic [9:0] paid_q, cost_q;
    logic [9:0] paid_calc, chg_calc;
    logic       accept, capture, wd_abort, proto_err, check_ok, wd_hit, in_wait;

    coin_valuer #(.CW(2)) u_paid (
        .n50   (req_n50),
        .n10   (req_n10),
        .n5    (req_n5),
        .n1    (req_n1),
        .value (paid_calc)
    );

    coin_valuer #(.CW(3)) u_change (
        .n50   (chg_n50),
        .n10   (chg_n10),
        .n5    (chg_n5),
        .n1    (chg_n1),
        .value (chg_calc)
    );

    assign in_wait = (state == ST_WAIT_ON) || (state == ST_WAIT_BUSY) ||
                     (state == ST_WAIT_OFF);
    assign wd_hit  = in_wait && (wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // A machine event in the same cycle as watchdog expiry wins.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        wd_abort   = 1'b0;
        proto_err  = 1'b0;
        item_req   = ITEM_NONE;
        coin_n50   = 2'd0;
        coin_n10   = 2'd0;
        coin_n5    = 2'd0;
        coin_n1    = 2'd0;
        case (state)
            ST_IDLE: begin
                if (start && (req_item != ITEM_NONE)) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT_ON;
                end
            end
            ST_WAIT_ON: begin
                if (svc_in == SVC_ON) begin
                    item_req   = item_q;
                    coin_n50   = n50_q;
                    coin_n10   = n10_q;
                    coin_n5    = n5_q;
                    coin_n1    = n1_q;
                    state_next = ST_WAIT_BUSY;
                end else if (wd_hit) begin
                    wd_abort   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                if (svc_in == SVC_BUSY) begin
                    state_next = ST_WAIT_OFF;
                end else if (svc_in == SVC_OFF) begin
                    proto_err  = 1'b1;
                    state_next = ST_IDLE;
                end else if (wd_hit) begin
                    wd_abort   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_OFF: begin
                if (svc_in == SVC_OFF) begin
                    capture    = 1'b1;
                    state_next = ST_CHECK;
                end else if (wd_hit) begin
                    wd_abort   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_CHECK: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NONE is a legal refund (underpayment or no change available).
    always_comb begin
        check_ok = 1'b0;
        if ((got_item == item_q) && (paid_q >= cost_q))
            check_ok = (change_value == paid_q - cost_q);
        else if (got_item == ITEM_NONE)
            check_ok = (change_value == paid_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wd           <= 8'd0;
            item_q       <= ITEM_NONE;
            n50_q        <= 2'd0;
            n10_q        <= 2'd0;
            n5_q         <= 2'd0;
            n1_q         <= 2'd0;
            paid_q       <= 10'd0;
            cost_q       <= 10'd0;
            change_value <= 10'd0;
            got_item     <= ITEM_NONE;
            done         <= 1'b0;
            err          <= 1'b0;
            timeout      <= 1'b0;
            txn_count    <= 8'd0;
        end else begin
            done <= 1'b0;
            if (state_next != state) wd <= 8'd0;
            else if (in_wait)        wd <= wd + 8'd1;

            if (accept) begin
                item_q <= req_item;
                n50_q  <= req_n50;
                n10_q  <= req_n10;
                n5_q   <= req_n5;
                n1_q   <= req_n1;
                paid_q <= paid_calc;
                cost_q <= item_cost(req_item, COST_A, COST_B, COST_C);
            end

            if (capture) begin
                got_item     <= item_in;
                change_value <= chg_calc;
            end

            if (state == ST_CHECK) begin
                done <= 1'b1;
                if (txn_count != 8'hFF) txn_count <= txn_count + 8'd1;
                if (!check_ok) err <= 1'b1;
            end

            if (wd_abort) begin
                timeout <= 1'b1;
                err     <= 1'b1;
            end
            if (proto_err) err <= 1'b1;
        end
    end

    assign busy       = (state != ST_IDLE);
    assign paid_value = paid_q[7:0];

endmodule

// File: tb/tb_vending_customer.sv
// Randomized bench: a behavioural vending machine answers each request and
// an abstract scoreboard predicts done/err/timeout/counters.
module tb_vending_customer;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [1:0] req_item, req_n50, req_n10, req_n5, req_n1, svc_in, item_in;
    logic [2:0] chg_n50, chg_n10, chg_n5, chg_n1;
    logic [1:0] coin_n50, coin_n10, coin_n5, coin_n1, item_req, got_item;
    logic       busy, done, err, timeout;
    logic [7:0] paid_value, txn_count;
    logic [9:0] change_value;

    int n_vec = 0;
    int n_bad = 0;
    int m_cnt = 0;
    bit m_err = 1'b0;
    bit m_to  = 1'b0;

    vending_customer dut (
        .clk(clk), .reset(reset), .start(start), .req_item(req_item),
        .req_n50(req_n50), .req_n10(req_n10), .req_n5(req_n5), .req_n1(req_n1),
        .svc_in(svc_in), .item_in(item_in),
        .chg_n50(chg_n50), .chg_n10(chg_n10), .chg_n5(chg_n5), .chg_n1(chg_n1),
        .coin_n50(coin_n50), .coin_n10(coin_n10), .coin_n5(coin_n5), .coin_n1(coin_n1),
        .item_req(item_req), .busy(busy), .done(done), .err(err), .timeout(timeout),
        .paid_value(paid_value), .change_value(change_value), .got_item(got_item),
        .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic int cost_of(input int it);
        case (it)
            1:       return 8;
            2:       return 15;
            3:       return 22;
            default: return 0;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_to"}, timeout, 0);
        chk({tag, "_req"}, {item_req, coin_n50, coin_n10, coin_n5, coin_n1}, 0);
        chk({tag, "_paid"}, paid_value, 0);
        chk({tag, "_chg"}, change_value, 0);
        chk({tag, "_got"}, got_item, 0);
        chk({tag, "_cnt"}, txn_count, 0);
    endtask

    // mode: 0 honest machine, 1 refund (no change), 2 one NTD too much change,
    // 3 wrong item delivered, 4 machine stalls in BUSY (returns in WAIT_OFF)
    task automatic run_txn(input int it, input int a, input int b, input int c,
                           input int d, input int mode, input bit dbl);
        int paid, cost, rem, gi, g50, g10, g5, g1, chv, dly, nb;
        bit ok;
        paid = 50 * a + 10 * b + 5 * c + d;
        cost = cost_of(it);
        if (mode == 1 || paid < cost) begin gi = 0; rem = paid; end
        else begin gi = it; rem = paid - cost; end
        if (mode == 3) gi = (it % 3) + 1;
        g50 = rem / 50; rem = rem % 50;
        g10 = rem / 10; rem = rem % 10;
        g5  = rem / 5;  g1 = rem % 5;
        if (mode == 2) g1++;
        chv = 50 * g50 + 10 * g10 + 5 * g5 + g1;
        ok  = (gi == it && paid >= cost && chv == paid - cost) || (gi == 0 && chv == paid);

        @(negedge clk);
        svc_in = 2'd1; start = 1'b1; req_item = 2'(it);
        req_n50 = 2'(a); req_n10 = 2'(b); req_n5 = 2'(c); req_n1 = 2'(d);
        @(negedge clk);
        start = 1'b0;
        req_item = 2'($urandom); req_n50 = 2'($urandom); req_n10 = 2'($urandom);
        req_n5 = 2'($urandom); req_n1 = 2'($urandom);
        chk("busy_on_start", busy, 1);
        dly = $urandom_range(0, 3);
        for (int k = 0; k < dly; k++) begin
            svc_in = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2;
            #1 chk("req_held_off", {item_req, coin_n50, coin_n10, coin_n5, coin_n1}, 0);
            @(negedge clk);
        end
        svc_in = 2'd1;
        #1;
        chk("item_req", item_req, it);
        chk("coins", {coin_n50, coin_n10, coin_n5, coin_n1},
            {2'(a), 2'(b), 2'(c), 2'(d)});
        chk("no_done_with_req", done, 0);
        @(negedge clk);
        svc_in = 2'd2;
        if (dbl) begin start = 1'b1; req_item = 2'd3; req_n50 = 2'd3; end
        #1 chk("req_one_cycle", item_req, 0);
        @(negedge clk);
        start = 1'b0;
        #1 chk("busy_wait", {busy, item_req}, {1'b1, 2'd0});
        if (mode == 4) return;
        nb = $urandom_range(0, 3);
        repeat (nb) @(negedge clk);
        svc_in = 2'd0; item_in = 2'(gi);
        chg_n50 = 3'(g50); chg_n10 = 3'(g10); chg_n5 = 3'(g5); chg_n1 = 3'(g1);
        @(negedge clk);
        svc_in = 2'd1; item_in = 2'd0;
        chg_n50 = 3'd0; chg_n10 = 3'd0; chg_n5 = 3'd0; chg_n1 = 3'd0;
        @(negedge clk);
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (!ok) m_err = 1'b1;
        chk("done", done, 1);
        chk("busy_clear", busy, 0);
        chk("err", err, m_err);
        chk("timeout", timeout, m_to);
        chk("txn_count", txn_count, m_cnt);
        chk("paid_value", paid_value, paid);
        chk("change_value", change_value, chv);
        chk("got_item", got_item, gi);
        @(negedge clk);
        #1 chk("idle_after", {done, busy, item_req}, 0);
    endtask

    initial begin
        int cyc;
        bit saw_done;
        reset = 1'b0; start = 1'b0; req_item = 2'd0;
        req_n50 = 2'd0; req_n10 = 2'd0; req_n5 = 2'd0; req_n1 = 2'd0;
        svc_in = 2'd1; item_in = 2'd0;
        chg_n50 = 3'd0; chg_n10 = 3'd0; chg_n5 = 3'd0; chg_n1 = 3'd0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;

        // B for 20 NTD: 5 back
        run_txn(2, 0, 2, 0, 0, 0, 1'b0);
        chk("t1_change", change_value, 5);
        chk("t1_err", err, 0);
        chk("t1_count", txn_count, 1);
        // C for 13 NTD: refunded
        run_txn(3, 0, 1, 0, 3, 0, 1'b0);
        chk("t2_got", got_item, 0);
        chk("t2_change", change_value, 13);

        for (int i = 0; i < 20; i++)
            run_txn($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? 1 : 0, 1'($urandom));

        // start with NONE is ignored
        @(negedge clk);
        start = 1'b1; req_item = 2'd0; req_n10 = 2'd2;
        @(negedge clk);
        start = 1'b0;
        #1 chk("none_ignored", {busy, item_req}, 0);
        @(negedge clk);
        chk("none_count", txn_count, m_cnt);

        // A paid 10, machine returns 3 instead of 2
        run_txn(1, 0, 1, 0, 0, 2, 1'b0);
        chk("t3_err", err, 1);
        for (int i = 0; i < 8; i++)
            run_txn($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom));
        chk("err_sticky", err, 1);

        // machine stays BUSY: TIMEOUT full cycles in WAIT_OFF, seen one negedge after the abort edge
        run_txn(2, 1, 0, 0, 0, 4, 1'b0);
        cyc = 1;
        saw_done = 1'b0;
        while (!timeout && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (done) saw_done = 1'b1;
        end
        m_to = 1'b1; m_err = 1'b1;
        chk("wd_cycles", cyc, 201);
        chk("wd_timeout", timeout, 1);
        chk("wd_err", err, 1);
        chk("wd_busy", busy, 0);
        chk("wd_no_done", saw_done, 0);
        chk("wd_count", txn_count, m_cnt);
        svc_in = 2'd1;

        // reset while waiting for OFF
        run_txn(3, 0, 2, 1, 0, 4, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        #1 check_zero("mid_reset");
        reset = 1'b1; svc_in = 2'd1;
        m_cnt = 0; m_err = 1'b0; m_to = 1'b0;
        run_txn(1, 0, 1, 0, 0, 0, 1'b0);
        chk("post_reset_count", txn_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
